game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Top-level game controller for the runner/flappy datapath.
- Owns the game state machine and the step-rate divider. Step rate is 3,000,000 cycles, i.e. 60 ms at 50 MHz.
- Captures jump presses and keeps score.
- Issues datapath steps only between display scans: a step fires only after a tick has elapsed and the display has reported end-of-frame. This prevents the datapath from updating while a frame is being drawn (tearing).

Parameters:
- TICK_DIV, 3000000: clock cycles per game tick.
- TICK_W, 28: width of the tick counter.
- OVER_HOLD, 16: number of frame_done pulses in OVER before go is honoured.
- TICK_STEP, 250000: reload reduction per speed level (used only with SEQ_SPEEDUP_EN).

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high
- go  in  1  level, start/restart request (inverted KEY[2])
- pause_req  in  1  level, pause toggle (inverted KEY[1])
- jump_btn  in  1  level, raw jump button (inverted KEY[3]); asynchronous
- lose  in  1  level from datapath, collision/ground hit
- pass  in  1  one-cycle pulse from datapath when an obstacle is cleared
- frame_done  in  1  one-cycle pulse from display at end of scan
- start  out  1  datapath load-initial-state level
- step  out  1  one-cycle datapath advance strobe
- jump  out  1  jump qualifier; valid only while step=1
- state  out  3  current state code
- score  out  16  4-digit BCD score
- overrun  out  1  sticky flag: a tick was lost

Behaviour:
- Reset (synchronous, active-high): state=IDLE, start=1, step=0, jump=0, score=0, overrun=0, all internal flags 0, tick counter loaded with TICK_DIV-1.
- States and transitions (evaluated at each clk edge):
  - IDLE(0): start=1. go=1 -> ARM.
  - ARM(1): start=1. Clears score, overrun, flags and speed level; reloads the counter. Waits for go=0 -> RUN, so one press never spans restart.
  - RUN(2): start=0.
    - lose=1 -> OVER. lose has priority over a simultaneous pause edge and over a simultaneous step.
    - Rising edge of pause_req -> PAUSE.
  - PAUSE(3): counter and flags frozen; step held 0.
    - Rising edge of pause_req -> RUN.
    - go=1 -> IDLE; go has priority if both occur together.
  - OVER(4): counts frame_done pulses, saturating at OVER_HOLD. Once the count reaches OVER_HOLD, go=1 -> IDLE.
- Tick divider (RUN only):
  - Counts down; at 0 it reloads and sets tick_pend.
  - If tick_pend is already 1 when a new tick arrives, overrun is set (sticky until ARM or reset).
- Frame lock:
  - frame_done sets frame_rdy in any state; frame_rdy is cleared in ARM.
  - step is registered: when RUN & tick_pend & frame_rdy hold at edge N, step=1 during cycle N+1, and tick_pend and frame_rdy clear at that same edge.
  - A tick arriving in the same cycle as step issue is re-captured into tick_pend, not lost.
- Jump capture:
  - jump_btn passes through a 2-flop synchroniser, then rising-edge detect.
  - An edge sets jump_lat. At a step, jump=jump_lat and jump_lat clears.
  - An edge coinciding with the step-issue edge is kept for the next step.
  - Edges outside RUN are discarded.
- Score:
  - +1 BCD per pass pulse, RUN only; pass is ignored in all other states and in the cycle RUN->OVER.
  - Saturates at 16'h9999.
  - Each digit carries 9->0 into the next digit.
- state output is the registered state code; start is decoded from the state.

Optional Feature:
- Macro: SEQ_SPEEDUP_EN.
- With the macro: a 3-bit level counter increments whenever the score's units digit wraps 9->0, saturating at 7, and clears in ARM. Tick reload = TICK_DIV-1 - level*TICK_STEP; the new value takes effect at the next reload.
- Without the macro: reload is always TICK_DIV-1; no level register exists.

Decomposition:
- Package game_pkg holds:
  - state codes S_IDLE=0, S_ARM=1, S_RUN=2, S_PAUSE=3, S_OVER=4 (3-bit);
  - BCD_MAX=16'h9999;
  - the default tick constants.
- Sub-module: seq_bcd_score, a 4-digit BCD incrementer with clear, saturation and a units-wrap pulse output (that pulse feeds the speed level).

Test Plan (bench uses TICK_DIV=10, OVER_HOLD=2):
- Reset asserted mid-RUN with score=0x0012 -> next cycle: state=0, start=1, score=0, step=0, overrun=0.
- go pulse, then release; frame_done every 4 cycles -> first step exactly 1 cycle after both tick_pend and frame_rdy are set; then step once every 10 cycles, never without a preceding frame_done.
- frame_done withheld for 25 cycles in RUN -> overrun=1 after the second tick; frame_done then produces exactly one step.
- jump_btn rises 3 cycles before a step -> that step carries jump=1 and the following step jump=0. An edge exactly at the step-issue edge -> jump=1 on the next step.
- 10000 pass pulses -> score saturates at 0x9999. lose and pause_req rise together -> OVER. go at the first frame_done in OVER is ignored; go after the second frame_done -> IDLE.
- SEQ_SPEEDUP_EN with TICK_STEP=1 -> after 10 passes, step spacing is 9 cycles; after 80+ passes it stays at 3.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// Shared state codes, BCD limit, default tick timing and the BCD increment helper
// used by the game sequencer and its score counter.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [15:0] BCD_MAX = 16'h9999;

    localparam int TICK_DIV_DEF  = 3000000;
    localparam int TICK_W_DEF    = 28;
    localparam int OVER_HOLD_DEF = 16;
    localparam int TICK_STEP_DEF = 250000;

    // Ripple a +1 through four BCD digits; each 9 rolls to 0 and carries on.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Control/datapath/display signal bundle of the game sequencer.
// master = sequencer side, slave = surrounding datapath, display and buttons.
interface game_sequencer_if;
    logic        go;
    logic        pause_req;
    logic        jump_btn;
    logic        lose;
    logic        pass;
    logic        frame_done;
    logic        start;
    logic        step;
    logic        jump;
    logic [2:0]  state;
    logic [15:0] score;
    logic        overrun;

    modport master (
        input  go, pause_req, jump_btn, lose, pass, frame_done,
        output start, step, jump, state, score, overrun
    );

    modport slave (
        output go, pause_req, jump_btn, lose, pass, frame_done,
        input  start, step, jump, state, score, overrun
    );
endinterface

// File: rtl/game_sequencer_bcd_score.sv
// 4-digit BCD score counter with clear and saturation at 9999; score updates one
// cycle after inc, units_wrap is combinational with the inc that rolls units 9->0.
module seq_bcd_score
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] score,
    output logic        units_wrap
);

    logic adv;

    assign adv        = inc && (score != BCD_MAX);
    assign units_wrap = adv && (score[3:0] == 4'd9);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            score <= '0;
        end else if (adv) begin
            score <= bcd_inc(score);
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game controller: state machine, tick divider, frame-locked step strobe (1 cycle after
// tick+frame), jump capture and BCD score; no backpressure. SEQ_SPEEDUP_EN adds speed levels.
module game_sequencer
    import game_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int TICK_W    = TICK_W_DEF,
    parameter int OVER_HOLD = OVER_HOLD_DEF,
    parameter int TICK_STEP = TICK_STEP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    game_sequencer_if.master  bus
);

    localparam int                OC_W        = $clog2(OVER_HOLD + 1);
    localparam logic [TICK_W-1:0] RELOAD_BASE = TICK_W'(TICK_DIV - 1);

    state_t            state, state_nxt;
    logic [TICK_W-1:0] cnt, reload;
    logic              tick_pend, frame_rdy, overrun, jump_lat;
    logic              step_q, jump_q, pause_prev, start;
    logic [2:0]        jsync;
    logic [OC_W-1:0]   over_cnt;
    logic              run, arm, tick, issue, jedge, pause_rise;
    logic              score_inc, units_wrap;
    logic [15:0]       score;

    assign run        = (state == S_RUN);
    assign arm        = (state == S_ARM);
    assign tick       = run && (cnt == '0);
    // A collision wins over a step that would otherwise issue this edge.
    assign issue      = run && tick_pend && frame_rdy && !bus.lose;
    assign jedge      = jsync[1] && !jsync[2];
    assign pause_rise = bus.pause_req && !pause_prev;
    assign score_inc  = run && bus.pass && !bus.lose;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            S_IDLE: begin
                start = 1'b1;
                if (bus.go) state_nxt = S_ARM;
            end
            S_ARM: begin
                start = 1'b1;
                if (!bus.go) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.lose)      state_nxt = S_OVER;
                else if (pause_rise) state_nxt = S_PAUSE;
            end
            S_PAUSE: begin
                if (bus.go)          state_nxt = S_IDLE;
                else if (pause_rise) state_nxt = S_RUN;
            end
            S_OVER: begin
                if (bus.go && over_cnt == OC_W'(OVER_HOLD)) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= RELOAD_BASE;
            tick_pend  <= 1'b0;
            frame_rdy  <= 1'b0;
            overrun    <= 1'b0;
            jump_lat   <= 1'b0;
            step_q     <= 1'b0;
            jump_q     <= 1'b0;
            jsync      <= '0;
            pause_prev <= 1'b0;
            over_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            pause_prev <= bus.pause_req;
            jsync      <= {jsync[1:0], bus.jump_btn};
            step_q     <= issue;
            jump_q     <= issue && jump_lat;

            if (arm) begin
                cnt       <= RELOAD_BASE;
                tick_pend <= 1'b0;
                frame_rdy <= 1'b0;
                overrun   <= 1'b0;
                jump_lat  <= 1'b0;
            end else begin
                if (run) cnt <= tick ? reload : cnt - TICK_W'(1);

                // A tick landing on the issue edge re-arms tick_pend instead of being dropped.
                if (issue)     tick_pend <= tick;
                else if (tick) tick_pend <= 1'b1;
                if (tick && tick_pend && !issue) overrun <= 1'b1;

                if (issue)               frame_rdy <= bus.frame_done;
                else if (bus.frame_done) frame_rdy <= 1'b1;

                if (run) begin
                    if (issue)      jump_lat <= jedge;
                    else if (jedge) jump_lat <= 1'b1;
                end
            end

            if (state != S_OVER)
                over_cnt <= '0;
            else if (bus.frame_done && over_cnt != OC_W'(OVER_HOLD))
                over_cnt <= over_cnt + OC_W'(1);
        end
    end

`ifdef SEQ_SPEEDUP_EN
    logic [2:0] level;

    always_ff @(posedge clk) begin
        if (reset || arm)                     level <= '0;
        else if (units_wrap && level != 3'd7) level <= level + 3'd1;
    end

    assign reload = RELOAD_BASE - TICK_W'(level) * TICK_W'(TICK_STEP);
`else
    localparam int step_unused = TICK_STEP;
    logic          wrap_unused;

    assign wrap_unused = units_wrap;
    assign reload      = RELOAD_BASE;
`endif

    seq_bcd_score u_score (
        .clk        (clk),
        .reset      (reset),
        .clr        (arm),
        .inc        (score_inc),
        .score      (score),
        .units_wrap (units_wrap)
    );

    assign bus.start   = start;
    assign bus.step    = step_q;
    assign bus.jump    = jump_q;
    assign bus.state   = state;
    assign bus.score   = score;
    assign bus.overrun = overrun;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with TICK_DIV=10, OVER_HOLD=2, TICK_STEP=1;
// edge numbers in the tasks count from the edge before the go press.
module tb_game_sequencer;
    import game_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   e           = 0;

    game_sequencer_if bus ();

    game_sequencer #(
        .TICK_DIV  (10),
        .TICK_W    (28),
        .OVER_HOLD (2),
        .TICK_STEP (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, edge=%0d", e);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic clk_edge;
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clk_edge();
        clk_edge();
        vectors++; if (bus.state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        vectors++; if (bus.start !== 1'b1) begin miscompares++; $display("FAIL reset_start: got %b want 1", bus.start); end
        vectors++; if (bus.step !== 1'b0) begin miscompares++; $display("FAIL reset_step: got %b want 0", bus.step); end
        vectors++; if (bus.jump !== 1'b0) begin miscompares++; $display("FAIL reset_jump: got %b want 0", bus.jump); end
        vectors++; if (bus.score !== 16'h0000) begin miscompares++; $display("FAIL reset_score: got %h want 0000", bus.score); end
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
        reset = 1'b0;
    endtask

    task automatic test_start;
        e      = 0;
        bus.go = 1'b1;
        clk_edge();
        vectors++; if (bus.state !== 3'd1) begin miscompares++; $display("FAIL start_arm_state: got %0d want 1", bus.state); end
        vectors++; if (bus.start !== 1'b1) begin miscompares++; $display("FAIL start_arm_start: got %b want 1", bus.start); end
        bus.go = 1'b0;
        clk_edge();
        vectors++; if (bus.state !== 3'd2) begin miscompares++; $display("FAIL start_run_state: got %0d want 2", bus.state); end
        vectors++; if (bus.start !== 1'b0) begin miscompares++; $display("FAIL start_run_start: got %b want 0", bus.start); end
        vectors++; if (bus.score !== 16'h0000) begin miscompares++; $display("FAIL start_score: got %h want 0000", bus.score); end
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL start_overrun: got %b want 0", bus.overrun); end
    endtask

    // Ticks at edges 12,22,32,42; frame_done every 4 edges; steps follow at 13,23,33,43.
    task automatic test_run;
        logic exp;
        for (int n = 3; n <= 43; n++) begin
            bus.frame_done = (n % 4 == 2);
            clk_edge();
            exp = (n == 13) || (n == 23) || (n == 33) || (n == 43);
            vectors++; if (bus.step !== exp) begin miscompares++; $display("FAIL run_step@%0d: got %b want %b", n, bus.step, exp); end
            vectors++; if (bus.jump !== 1'b0) begin miscompares++; $display("FAIL run_jump@%0d: got %b want 0", n, bus.jump); end
        end
        bus.frame_done = 1'b0;
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL run_overrun: got %b want 0", bus.overrun); end
    endtask

    // No frames until edge 69: ticks at 52 and 62 collide -> overrun; one step at 70.
    task automatic test_overrun;
        logic exp_step, exp_ovr;
        for (int n = 44; n <= 78; n++) begin
            bus.frame_done = (n == 69);
            clk_edge();
            exp_step = (n == 70);
            exp_ovr  = (n >= 62);
            vectors++; if (bus.step !== exp_step) begin miscompares++; $display("FAIL ovr_step@%0d: got %b want %b", n, bus.step, exp_step); end
            vectors++; if (bus.overrun !== exp_ovr) begin miscompares++; $display("FAIL ovr_flag@%0d: got %b want %b", n, bus.overrun, exp_ovr); end
        end
        bus.frame_done = 1'b0;
    endtask

    // Press latched at 81 rides step 82; step 85 is clean; edge at issue edge 93 rides step 103.
    task automatic test_jump;
        logic exp_step, exp_jump;
        for (int n = 79; n <= 104; n++) begin
            bus.jump_btn   = (n >= 79 && n <= 85) || (n >= 91 && n <= 93);
            bus.frame_done = (n == 81) || (n == 84) || (n == 90) || (n == 100);
            clk_edge();
            exp_step = (n == 82) || (n == 85) || (n == 93) || (n == 103);
            exp_jump = (n == 82) || (n == 103);
            vectors++; if (bus.step !== exp_step) begin miscompares++; $display("FAIL jump_step@%0d: got %b want %b", n, bus.step, exp_step); end
            vectors++; if (bus.jump !== exp_jump) begin miscompares++; $display("FAIL jump_flag@%0d: got %b want %b", n, bus.jump, exp_jump); end
        end
        bus.jump_btn   = 1'b0;
        bus.frame_done = 1'b0;
    endtask

    task automatic test_score_small;
        for (int k = 1; k <= 12; k++) begin
            bus.pass = 1'b1;
            clk_edge();
            vectors++; if (bus.score !== to_bcd(k)) begin miscompares++; $display("FAIL score_count@%0d: got %h want %h", k, bus.score, to_bcd(k)); end
        end
        bus.pass = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        vectors++; if (bus.score !== 16'h0012) begin miscompares++; $display("FAIL midrst_pre_score: got %h want 0012", bus.score); end
        reset = 1'b1;
        clk_edge();
        vectors++; if (bus.state !== 3'd0) begin miscompares++; $display("FAIL midrst_state: got %0d want 0", bus.state); end
        vectors++; if (bus.start !== 1'b1) begin miscompares++; $display("FAIL midrst_start: got %b want 1", bus.start); end
        vectors++; if (bus.score !== 16'h0000) begin miscompares++; $display("FAIL midrst_score: got %h want 0000", bus.score); end
        vectors++; if (bus.step !== 1'b0) begin miscompares++; $display("FAIL midrst_step: got %b want 0", bus.step); end
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL midrst_overrun: got %b want 0", bus.overrun); end
        reset = 1'b0;
    endtask

    task automatic test_lose_over;
        logic [2:0] exp_state;
        bus.lose      = 1'b1;
        bus.pause_req = 1'b1;
        bus.pass      = 1'b1;
        clk_edge();
        vectors++; if (bus.state !== 3'd4) begin miscompares++; $display("FAIL lose_state: got %0d want 4", bus.state); end
        vectors++; if (bus.score !== 16'h0000) begin miscompares++; $display("FAIL lose_pass_ignored: got %h want 0000", bus.score); end
        bus.lose      = 1'b0;
        bus.pause_req = 1'b0;
        clk_edge();
        vectors++; if (bus.score !== 16'h0000) begin miscompares++; $display("FAIL over_pass_ignored: got %h want 0000", bus.score); end
        bus.pass = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            bus.go         = 1'b1;
            bus.frame_done = (n == 2) || (n == 4);
            clk_edge();
            exp_state = (n == 5) ? 3'd0 : 3'd4;
            vectors++; if (bus.state !== exp_state) begin miscompares++; $display("FAIL over_hold@%0d: got %0d want %0d", n, bus.state, exp_state); end
        end
        bus.go         = 1'b0;
        bus.frame_done = 1'b0;
        clk_edge();
        vectors++; if (bus.state !== 3'd0) begin miscompares++; $display("FAIL over_idle: got %0d want 0", bus.state); end
    endtask

    task automatic test_saturate;
        logic [15:0] exp;
        for (int n = 1; n <= 10000; n++) begin
            bus.pass = 1'b1;
            clk_edge();
            if (n == 9 || n == 99 || n == 1000 || n == 9999 || n == 10000) begin
                exp = to_bcd((n > 9999) ? 9999 : n);
                vectors++; if (bus.score !== exp) begin miscompares++; $display("FAIL sat_score@%0d: got %h want %h", n, bus.score, exp); end
            end
        end
        bus.pass = 1'b0;
    endtask

    task automatic test_pause;
        logic [7:0] pz   = 8'b1010_1011;  // bit i = pause_req for step i
        logic [7:0] gz   = 8'b1000_0000;
        logic [2:0] exps [8] = '{3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd3, 3'd3, 3'd0};
        for (int i = 0; i < 8; i++) begin
            bus.pause_req = pz[i];
            bus.go        = gz[i];
            clk_edge();
            vectors++; if (bus.state !== exps[i]) begin miscompares++; $display("FAIL pause_state@%0d: got %0d want %0d", i, bus.state, exps[i]); end
            if (exps[i] == 3'd3) begin
                vectors++; if (bus.step !== 1'b0) begin miscompares++; $display("FAIL pause_step@%0d: got %b want 0", i, bus.step); end
            end
        end
        bus.pause_req = 1'b0;
        bus.go        = 1'b0;
    endtask

`ifdef SEQ_SPEEDUP_EN
    task automatic find_gap(output int gap, output bit ok);
        int t [4];
        int found = 0;
        for (int k = 0; k < 80 && found < 4; k++) begin
            clk_edge();
            if (bus.step === 1'b1) begin
                t[found] = e;
                found++;
            end
        end
        ok  = (found == 4);
        gap = ok ? (t[3] - t[2]) : -1;
    endtask

    task automatic test_speedup;
        int gap;
        bit ok;
        bus.frame_done = 1'b1;
        for (int n = 0; n < 10; n++) begin bus.pass = 1'b1; clk_edge(); end
        bus.pass = 1'b0;
        find_gap(gap, ok);
        vectors++; if (!ok || gap != 9) begin miscompares++; $display("FAIL speed_lvl1_gap: got %0d want 9", gap); end
        for (int n = 0; n < 80; n++) begin bus.pass = 1'b1; clk_edge(); end
        bus.pass = 1'b0;
        find_gap(gap, ok);
        vectors++; if (!ok || gap != 3) begin miscompares++; $display("FAIL speed_lvl7_gap: got %0d want 3", gap); end
        bus.frame_done = 1'b0;
    endtask
`endif

    initial begin
        reset          = 1'b1;
        bus.go         = 1'b0;
        bus.pause_req  = 1'b0;
        bus.jump_btn   = 1'b0;
        bus.lose       = 1'b0;
        bus.pass       = 1'b0;
        bus.frame_done = 1'b0;

        test_reset();
        test_start();
        test_run();
        test_overrun();
        test_jump();
        test_score_small();
        test_reset_mid_run();
        test_start();
        test_lose_over();
        test_start();
        test_saturate();
        test_pause();
`ifdef SEQ_SPEEDUP_EN
        test_start();
        test_speedup();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
